// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one-at-a-time memory
// requests and buffers returned words with their PCs for the IF/ID register.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [31:0]    fetch_pc, fetch_pc_nxt;
    logic [31:0]    addr_nxt;
    logic           req_nxt;
    logic [CW-1:0]  count;
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [31:0]    pc_mem    [DEPTH];
    logic [31:0]    instr_mem [DEPTH];

    logic           ack, push, pop, room;
    logic [CW:0]    occ;
    logic [31:0]    redir_pc;

    // Acks only mean something while a request is actually outstanding.
    assign ack      = imem_ack & imem_req;
    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? pc_mem[rd_ptr]    : '0;
    assign if_instr = if_valid ? instr_mem[rd_ptr] : '0;
    assign pop      = if_valid & id_ready & ~redirect;
    assign push     = ack & (state == REQ) & ~redirect;
    assign redir_pc = redirect_pc & ~32'h3;

    // Occupancy after this edge if one more request were issued now.
    assign occ  = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, 1'b1};
    assign room = (occ <= (CW+1)'(DEPTH));

    always_comb begin
        state_nxt    = state;
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        fetch_pc_nxt = fetch_pc;
        if (redirect) begin
            fetch_pc_nxt = redir_pc;
            if (state != IDLE) begin
                if (ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DRAIN;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (room) begin
                        req_nxt   = 1'b1;
                        addr_nxt  = fetch_pc;
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        fetch_pc_nxt = imem_addr + 32'd4;
                        if (room) begin
                            addr_nxt = imem_addr + 32'd4;
                        end else begin
                            req_nxt   = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        req_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO payload carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= imem_addr;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule
